exec_unit: RTL
==============

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of operands and result; only 16 is supported.
REQ-002 Parameter: ADDR_W, 3, register-file address width (8 registers).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  request to execute one operation; sampled on the clk edge.
REQ-006 Port: op  input  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
REQ-007 Port: srcA  input  WIDTH  operand A (register-file readData1).
REQ-008 Port: srcB  input  WIDTH  operand B (register-file readData2).
REQ-009 Port: destAddr  input  ADDR_W  destination register for the result.
REQ-010 Port: busy  output  1  high while an operation is in progress; start is ignored.
REQ-011 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-012 Port: writeEn  output  1  register-file write enable; identical to done.
REQ-013 Port: writeAddr  output  ADDR_W  destination address, valid while done=1.
REQ-014 Port: writeData  output  WIDTH  result, valid while done=1.
REQ-015 Port: zero  output  1  high when writeData==0, valid while done=1.
REQ-016 Port: ovf  output  1  signed overflow for ADD/SUB, 0 for all other ops, valid while done=1.

Function
REQ-017 FSM states: IDLE, MUL, DONE; busy=1 in any state other than IDLE; all outputs are registered.
REQ-018 In IDLE with start=1, the block captures op, srcA, srcB and destAddr; later changes on these inputs do not affect the operation.
REQ-019 Non-MUL op accepted on edge k: next state is DONE, and done/writeEn=1 during the cycle after edge k (latency 1).
REQ-020 MUL accepted on edge k: the block enters MUL for 16 cycles (shift-add, one bit of B per cycle, LSB first), then DONE; done is asserted 17 cycles after edge k.
REQ-021 DONE lasts exactly one cycle, then the FSM returns to IDLE; start in DONE or MUL is ignored and not queued.
REQ-022 ADD/SUB: result is modulo 2^16; ovf=1 when the operands' signs and the result's sign indicate two's-complement overflow.
REQ-023 SLL/SRL: shift srcA by srcB[3:0]; logical shift, zero fill; srcB[15:4] is ignored; shift by 0 returns srcA.
REQ-024 MUL: writeData = low 16 bits of unsigned srcA*srcB; upper bits are discarded; no flag for it.
REQ-025 AND/OR/XOR: bitwise on the full 16 bits.
REQ-026 Outside DONE: done=writeEn=0; writeData, writeAddr, zero and ovf hold their last values.
REQ-027 Maximum throughput is one non-MUL op per 2 cycles.

Reset
REQ-028 When reset=1 on an edge, the state becomes IDLE; busy=0, done=0, writeEn=0, writeData=0, writeAddr=0, zero=0, ovf=0.
REQ-029 Reset mid-MUL aborts the operation; no writeEn pulse is produced for it.
REQ-030 Reset has priority over start on the same edge.

Verification
REQ-031 ADD 0x7FFF+0x0001, dest 3 -> one cycle later: done=writeEn=1, writeData=0x8000, writeAddr=3, ovf=1, zero=0.
REQ-032 SUB 0x1234-0x1234, dest 5 -> writeData=0x0000, zero=1, ovf=0; done is high for exactly one cycle.
REQ-033 MUL 0x0123*0x0010, dest 7 -> busy=1 for 17 cycles; done on cycle 17 with writeData=0x1230. MUL 0xFFFF*0xFFFF -> writeData=0x0001.
REQ-034 SLL 0x0001 by srcB=0x0013 -> writeData=0x0008. SRL 0x8000 by 15 -> writeData=0x0001.
REQ-035 start pulsed during MUL with a different op -> ignored; only the MUL result is written; a start one cycle after DONE is accepted.
REQ-036 Reset asserted in cycle 8 of a MUL -> busy=0 on the next cycle, no writeEn pulse, and all outputs are 0.

Source files
------------

// File: rtl/exec_unit.sv
// Single-issue execution unit: ALU ops finish in one cycle, MUL runs a 16-step shift-add.
// Results are presented as a one-cycle register-file write pulse.
module exec_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  srcA,
    input  logic [WIDTH-1:0]  srcB,
    input  logic [ADDR_W-1:0] destAddr,
    output logic              busy,
    output logic              done,
    output logic              writeEn,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [WIDTH-1:0]  writeData,
    output logic              zero,
    output logic              ovf
);
    // state | meaning
    // IDLE  | waiting for start
    // MUL   | shift-add multiply, one bit of B per cycle
    // DONE  | result on the write port for one cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              zero_q, zero_d, ovf_q, ovf_d;

    logic [WIDTH-1:0]  alu_res, sum, diff, acc_step;
    logic              alu_ovf;

    always_comb begin
        sum      = srcA + srcB;
        diff     = srcA - srcB;
        alu_res  = '0;
        alu_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_AND:  alu_res = srcA & srcB;
            OP_OR:   alu_res = srcA | srcB;
            OP_XOR:  alu_res = srcA ^ srcB;
            OP_SLL:  alu_res = srcA << srcB[3:0];
            OP_SRL:  alu_res = srcA >> srcB[3:0];
            default: alu_res = '0;
        endcase
    end

    assign acc_step = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        a_d     = srcA;
                        b_d     = srcB;
                        addr_d  = destAddr;
                        acc_d   = '0;
                        cnt_d   = 4'd15;
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        wdata_d = alu_res;
                        waddr_d = destAddr;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                // terminal count: this edge applies the 16th partial product
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    wdata_d = acc_step;
                    waddr_d = addr_q;
                    zero_d  = (acc_step == '0);
                    ovf_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign writeEn   = done_q;
    assign writeAddr = waddr_q;
    assign writeData = wdata_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
endmodule
